// File: rtl/rst_seq_pkg.sv
// Shared types and constants for the FPGA reset sequencer.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    ST_WAIT_LOCK,
    ST_REL_PERIPH,
    ST_RUN,
    ST_HOLD
  } rst_seq_state_e;

  localparam int CauseW    = 5;
  localparam int CausePor  = 0;
  localparam int CauseLock = 1;
  localparam int CauseBtn  = 2;
  localparam int CauseJtag = 3;
  localparam int CauseSw   = 4;

  localparam logic [CauseW-1:0] PorCause = CauseW'(1) << CausePor;

  function automatic int max3(int a, int b, int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/prim_flop_2sync.sv
// Two-flop synchroniser for single-bit asynchronous inputs.
module prim_flop_2sync #(
  parameter bit ResetValue = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= ResetValue;
      q_o    <= ResetValue;
    end else begin
      meta_q <= d_i;
      q_o    <= meta_q;
    end
  end

endmodule

// File: rtl/rst_seq_debounce.sv
// Button debouncer: synchronise, then require DebounceCycles consecutive lows.
module rst_seq_debounce #(
  parameter int DebounceCycles = 65536
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_ni,
  output logic req_o
);

  localparam int              CntW   = $clog2(DebounceCycles + 1);
  localparam logic [CntW-1:0] CntTop = CntW'(DebounceCycles - 1);

  logic            btn_s;
  logic [CntW-1:0] cnt_q;

  prim_flop_2sync #(.ResetValue(1'b0)) u_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (btn_ni),
    .q_o    (btn_s)
  );

  // Saturates at the threshold so the request holds for as long as the button does.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)              cnt_q <= '0;
    else if (btn_s)           cnt_q <= '0;
    else if (cnt_q != CntTop) cnt_q <= cnt_q + 1'b1;
  end

  assign req_o = !btn_s && (cnt_q == CntTop);

endmodule

// File: rtl/fpga_rst_seq.sv
// Reset sequencer: staged periphery/system release with cause capture.
module fpga_rst_seq
  import rst_seq_pkg::*;
#(
  parameter int LockStableCycles = 1024,
  parameter int DebounceCycles   = 65536,
  parameter int StageDelay       = 16,
  parameter int MinHoldCycles    = 256
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              pll_locked_i,
  input  logic              ext_rst_ni,
  input  logic              jtag_srst_ni,
  input  logic              sw_rst_req_i,
  output logic              rst_periph_no,
  output logic              rst_sys_no,
  output logic              seq_busy_o,
  output logic [CauseW-1:0] rst_cause_o
);

  localparam int CntW = $clog2(max3(LockStableCycles, StageDelay, MinHoldCycles) + 1);

  logic lock_s, jtag_s, btn_req, req_active, lock_ok_q;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [CauseW-1:0] ev, cause_q;
  logic periph_q, sys_q, busy_q;
  rst_seq_state_e state_q, state_d;

  prim_flop_2sync #(.ResetValue(1'b0)) u_lock_sync (
    .clk_i (clk_i), .rst_ni (rst_ni), .d_i (pll_locked_i), .q_o (lock_s)
  );

  prim_flop_2sync #(.ResetValue(1'b0)) u_jtag_sync (
    .clk_i (clk_i), .rst_ni (rst_ni), .d_i (jtag_srst_ni), .q_o (jtag_s)
  );

  rst_seq_debounce #(.DebounceCycles(DebounceCycles)) u_btn (
    .clk_i (clk_i), .rst_ni (rst_ni), .btn_ni (ext_rst_ni), .req_o (btn_req)
  );

  assign req_active = btn_req || !jtag_s;

  always_comb begin
    ev            = '0;
    ev[CauseLock] = !lock_s;
    ev[CauseBtn]  = btn_req;
    ev[CauseJtag] = !jtag_s;
    ev[CauseSw]   = sw_rst_req_i && (state_q == ST_RUN);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_WAIT_LOCK:  if (lock_ok_q && lock_s && !req_active) state_d = ST_REL_PERIPH;
      ST_REL_PERIPH: begin
        if (!lock_s)                                state_d = ST_HOLD;
        else if (cnt_q == CntW'(StageDelay - 1))    state_d = ST_RUN;
      end
      ST_RUN:        if (|ev) state_d = ST_HOLD;
      ST_HOLD:       if (cnt_q == CntW'(MinHoldCycles - 1)) state_d = ST_WAIT_LOCK;
      default:       state_d = ST_WAIT_LOCK;
    endcase
  end

  // One shared counter: lock-stable count in WAIT_LOCK, stage/hold delay elsewhere.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (state_d != state_q || state_q == ST_RUN) cnt_d = '0;
    else if (state_q == ST_WAIT_LOCK) begin
      if (!lock_s)                                  cnt_d = '0;
      else if (cnt_q == CntW'(LockStableCycles - 1)) cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_WAIT_LOCK;
      cnt_q     <= '0;
      lock_ok_q <= 1'b0;
      periph_q  <= 1'b0;
      sys_q     <= 1'b0;
      busy_q    <= 1'b1;
      cause_q   <= PorCause;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      // Lock-stable flag adds one stage so release lands at sync + count + register.
      lock_ok_q <= (state_q == ST_WAIT_LOCK) && (state_d == ST_WAIT_LOCK) && lock_s &&
                   (cnt_q == CntW'(LockStableCycles - 1));
      periph_q  <= (state_d == ST_REL_PERIPH) || (state_d == ST_RUN);
      sys_q     <= (state_d == ST_RUN);
      busy_q    <= (state_d != ST_RUN);
      if (state_q != ST_HOLD && state_d == ST_HOLD) cause_q <= ev;
    end
  end

  assign rst_periph_no = periph_q;
  assign rst_sys_no    = sys_q;
  assign seq_busy_o    = busy_q;
  assign rst_cause_o   = cause_q;

endmodule

// File: tb/tb_fpga_rst_seq.sv
// Directed bench for fpga_rst_seq with small parameters; edge counts are hand-derived.
module tb_fpga_rst_seq;

  logic       clk_i = 1'b0;
  logic       rst_ni, pll_locked_i, ext_rst_ni, jtag_srst_ni, sw_rst_req_i;
  logic       rst_periph_no, rst_sys_no, seq_busy_o;
  logic [4:0] rst_cause_o;

  int n_assert = 0;
  int n_fail   = 0;

  fpga_rst_seq #(
    .LockStableCycles (8),
    .DebounceCycles   (16),
    .StageDelay       (4),
    .MinHoldCycles    (32)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .pll_locked_i  (pll_locked_i),
    .ext_rst_ni    (ext_rst_ni),
    .jtag_srst_ni  (jtag_srst_ni),
    .sw_rst_req_i  (sw_rst_req_i),
    .rst_periph_no (rst_periph_no),
    .rst_sys_no    (rst_sys_no),
    .seq_busy_o    (seq_busy_o),
    .rst_cause_o   (rst_cause_o)
  );

  always #5 clk_i = ~clk_i;

  // Advance n rising edges, then settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [4:0] got, input logic [4:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic p, input logic s, input logic b);
    chk({tag, ".periph"}, 5'(rst_periph_no), 5'(p));
    chk({tag, ".sys"},    5'(rst_sys_no),    5'(s));
    chk({tag, ".busy"},   5'(seq_busy_o),    5'(b));
  endtask

  initial begin
    rst_ni = 1'b0; pll_locked_i = 1'b0; ext_rst_ni = 1'b1;
    jtag_srst_ni = 1'b1; sw_rst_req_i = 1'b0;
    tick(3);
    chk_outs("reset", 1'b0, 1'b0, 1'b1);
    chk("reset.cause", rst_cause_o, 5'b00001);

    // Power-on: release and lock rise before edge 1.
    rst_ni = 1'b1; pll_locked_i = 1'b1;
    tick(10); chk_outs("por.e10", 1'b0, 1'b0, 1'b1);
    tick(1);  chk_outs("por.e11", 1'b1, 1'b0, 1'b1);
    tick(3);  chk_outs("por.e14", 1'b1, 1'b0, 1'b1);
    tick(1);  chk_outs("por.e15", 1'b1, 1'b1, 1'b0);
    chk("por.cause", rst_cause_o, 5'b00001);

    // Button bounce: 10-cycle lows never reach the 16-cycle threshold.
    for (int i = 0; i < 3; i++) begin
      ext_rst_ni = 1'b0; tick(10);
      ext_rst_ni = 1'b1; tick(5);
    end
    chk_outs("bounce", 1'b1, 1'b1, 1'b0);
    chk("bounce.cause", rst_cause_o, 5'b00001);

    // 20-cycle low press.
    ext_rst_ni = 1'b0;
    tick(17); chk_outs("btn.k17", 1'b1, 1'b1, 1'b0);
    tick(1);  chk_outs("btn.k18", 1'b0, 1'b0, 1'b1);
    chk("btn.cause", rst_cause_o, 5'b00100);
    tick(2);  ext_rst_ni = 1'b1;
    tick(29); chk_outs("btn.k49", 1'b0, 1'b0, 1'b1);
    tick(9);  chk_outs("btn.k58", 1'b0, 1'b0, 1'b1);
    tick(1);  chk_outs("btn.k59", 1'b1, 1'b0, 1'b1);
    tick(4);  chk_outs("btn.k63", 1'b1, 1'b1, 1'b0);

    // Software reset pulse in RUN.
    sw_rst_req_i = 1'b1;
    tick(1);  sw_rst_req_i = 1'b0;
    chk_outs("sw.k1", 1'b0, 1'b0, 1'b1);
    chk("sw.cause", rst_cause_o, 5'b10000);
    tick(31); chk_outs("sw.k32", 1'b0, 1'b0, 1'b1);
    tick(9);  chk_outs("sw.k41", 1'b0, 1'b0, 1'b1);
    tick(1);  chk_outs("sw.k42", 1'b1, 1'b0, 1'b1);
    tick(3);  chk_outs("sw.k45", 1'b1, 1'b0, 1'b1);
    tick(1);  chk_outs("sw.k46", 1'b1, 1'b1, 1'b0);

    // JTAG srst and lock loss together.
    jtag_srst_ni = 1'b0; pll_locked_i = 1'b0;
    tick(2);  chk_outs("jl.k2", 1'b1, 1'b1, 1'b0);
    tick(1);  chk_outs("jl.k3", 1'b0, 1'b0, 1'b1);
    chk("jl.cause", rst_cause_o, 5'b01010);
    tick(2);  pll_locked_i = 1'b1;
    tick(45); chk_outs("jl.k50", 1'b0, 1'b0, 1'b1);
    jtag_srst_ni = 1'b1;
    tick(2);  chk_outs("jl.k52", 1'b0, 1'b0, 1'b1);
    tick(1);  chk_outs("jl.k53", 1'b1, 1'b0, 1'b1);
    tick(4);  chk_outs("jl.k57", 1'b1, 1'b1, 1'b0);
    chk("jl.cause_held", rst_cause_o, 5'b01010);

    // Async reset while in REL_PERIPH.
    rst_ni = 1'b0;
    tick(2);
    rst_ni = 1'b1;
    tick(11); chk_outs("arst.e11", 1'b1, 1'b0, 1'b1);
    tick(1);  #2 rst_ni = 1'b0;
    #1 chk_outs("arst.async", 1'b0, 1'b0, 1'b1);
    chk("arst.cause", rst_cause_o, 5'b00001);

    // Lock loss during REL_PERIPH.
    tick(2);
    rst_ni = 1'b1;
    tick(11); chk_outs("rl.e11", 1'b1, 1'b0, 1'b1);
    pll_locked_i = 1'b0;
    tick(2);  chk_outs("rl.e13", 1'b1, 1'b0, 1'b1);
    tick(1);  chk_outs("rl.e14", 1'b0, 1'b0, 1'b1);
    chk("rl.cause", rst_cause_o, 5'b00010);

    // Lock glitch during the stability count restarts it.
    rst_ni = 1'b0;
    tick(2);
    rst_ni = 1'b1; pll_locked_i = 1'b1;
    tick(5);  pll_locked_i = 1'b0;
    tick(1);  pll_locked_i = 1'b1;
    tick(10); chk_outs("gl.e16", 1'b0, 1'b0, 1'b1);
    tick(1);  chk_outs("gl.e17", 1'b1, 1'b0, 1'b1);
    tick(4);  chk_outs("gl.e21", 1'b1, 1'b1, 1'b0);
    chk("gl.cause", rst_cause_o, 5'b00001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
